// File: rtl/pipe_flush_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   maint_state_e : maintenance sequencer states
//   TGT_*         : bit positions of the maintenance targets in tgt_req/tgt_ack
//   DEF_*         : default geometry used by the top, the interface and the bench
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_REFETCH = 2'd3
  } maint_state_e;

  localparam int TGT_TLB    = 0;
  localparam int TGT_ICACHE = 1;
  localparam int TGT_DCACHE = 2;
  localparam int TGT_BTB    = 3;

  localparam int DEF_NUM_STAGES = 8;
  localparam int DEF_PC_W       = 32;
  localparam int DEF_NUM_TGT    = 4;
  localparam int DEF_MAINT_STG  = 5;

endpackage

// File: rtl/pipe_flush_ctrl_if.sv
// Bundle of every pipeline/maintenance signal exchanged with pipe_flush_ctrl.
//   master : pipeline + maintenance targets side (drives requests/acks)
//   slave  : the controller (drives flush/stall/redirect/tgt_req/busy)
interface pipe_flush_ctrl_if #(
  parameter int NUM_STAGES = pipe_ctrl_pkg::DEF_NUM_STAGES,
  parameter int PC_W       = pipe_ctrl_pkg::DEF_PC_W,
  parameter int NUM_TGT    = pipe_ctrl_pkg::DEF_NUM_TGT
);

  logic [NUM_STAGES-1:0]      flush_req;
  logic [NUM_STAGES*PC_W-1:0] flush_pc;
  logic [NUM_STAGES-1:0]      stall_req;
  logic                       maint_valid;
  logic [NUM_TGT-1:0]         maint_tgt;
  logic [PC_W-1:0]            maint_pc;
  logic [NUM_TGT-1:0]         tgt_ack;
  logic [NUM_STAGES-1:0]      flush_out;
  logic [NUM_STAGES-1:0]      stall_out;
  logic                       redirect_vld;
  logic [PC_W-1:0]            redirect_pc;
  logic [NUM_TGT-1:0]         tgt_req;
  logic                       maint_busy;

  modport master (
    output flush_req, flush_pc, stall_req, maint_valid, maint_tgt, maint_pc, tgt_ack,
    input  flush_out, stall_out, redirect_vld, redirect_pc, tgt_req, maint_busy
  );

  modport slave (
    input  flush_req, flush_pc, stall_req, maint_valid, maint_tgt, maint_pc, tgt_ack,
    output flush_out, stall_out, redirect_vld, redirect_pc, tgt_req, maint_busy
  );

endinterface

// File: rtl/pipe_flush_ctrl_chk.sv
// Protocol checker for pipe_flush_ctrl, kept apart from the design logic.
// Ports: clk, aresetn, maint_valid, maint_tgt, maint_busy (all observed only).
module pipe_flush_ctrl_chk #(
  parameter int NUM_TGT = pipe_ctrl_pkg::DEF_NUM_TGT
) (
  input logic               clk,
  input logic               aresetn,
  input logic               maint_valid,
  input logic [NUM_TGT-1:0] maint_tgt,
  input logic               maint_busy
);

  // The pipeline is held while an op runs, so no second op may arrive.
  a_no_valid_when_busy: assert property (@(posedge clk) disable iff (!aresetn)
    !(maint_valid && maint_busy));

  // An op with no targets would never be requested anywhere.
  a_tgt_nonzero: assert property (@(posedge clk) disable iff (!aresetn)
    maint_valid |-> (maint_tgt != '0));

endmodule

// File: rtl/pipe_flush_ctrl_maint_seq.sv
// Maintenance-op sequencer: IDLE -> ISSUE -> WAIT -> REFETCH -> IDLE.
// Ports:
//   clk, aresetn  clock / async active-low reset
//   maint_valid   maintenance instruction present at the issuing stage (1-cycle pulse)
//   maint_tgt     targets to operate on
//   maint_pc      PC of the maintenance instruction
//   tgt_ack       per-target done pulse
//   older_flush   a stage older than the issuing stage is flushing this cycle
//   tgt_req       per-target level request, dropped on its ack
//   maint_busy    sequencer not idle
//   hold          pipeline up to the issuing stage must be held (ISSUE/WAIT)
//   refetch       one-cycle refetch flush/redirect (REFETCH, not killed)
//   refetch_pc    maint_pc + 4
module maint_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int NUM_TGT = DEF_NUM_TGT
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic               maint_valid,
  input  logic [NUM_TGT-1:0] maint_tgt,
  input  logic [PC_W-1:0]    maint_pc,
  input  logic [NUM_TGT-1:0] tgt_ack,
  input  logic               older_flush,
  output logic [NUM_TGT-1:0] tgt_req,
  output logic               maint_busy,
  output logic               hold,
  output logic               refetch,
  output logic [PC_W-1:0]    refetch_pc
);

  maint_state_e       state_r;
  logic [NUM_TGT-1:0] tgt_mask_r;
  logic [NUM_TGT-1:0] ack_mask_r;
  logic [NUM_TGT-1:0] tgt_req_r;
  logic [PC_W-1:0]    refetch_pc_r;
  logic               killed_r;
  logic               busy_r;
  logic               hold_r;
  logic               refetch_r;

  logic [NUM_TGT-1:0] acc_ack_s;
  logic               all_done_s;

  // Acks are only meaningful for targets this op actually requested.
  always_comb begin
    acc_ack_s  = tgt_ack & tgt_mask_r;
    all_done_s = ((ack_mask_r | acc_ack_s) == tgt_mask_r);
  end

  // Sequencer state, latches and registered outputs.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_r      <= ST_IDLE;
      tgt_mask_r   <= {NUM_TGT{1'b0}};
      ack_mask_r   <= {NUM_TGT{1'b0}};
      tgt_req_r    <= {NUM_TGT{1'b0}};
      refetch_pc_r <= {PC_W{1'b0}};
      killed_r     <= 1'b0;
      busy_r       <= 1'b0;
      hold_r       <= 1'b0;
      refetch_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ack_mask_r <= {NUM_TGT{1'b0}};
          killed_r   <= 1'b0;
          refetch_r  <= 1'b0;
          if (maint_valid) begin
            // Request goes out at the same edge so it is visible one cycle after maint_valid.
            tgt_mask_r   <= maint_tgt;
            tgt_req_r    <= maint_tgt;
            refetch_pc_r <= maint_pc + PC_W'(32'd4);
            busy_r       <= 1'b1;
            hold_r       <= 1'b1;
            state_r      <= ST_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          // A target may answer in the very first request cycle; keep that ack.
          ack_mask_r <= ack_mask_r | acc_ack_s;
          tgt_req_r  <= tgt_req_r & ~acc_ack_s;
          killed_r   <= killed_r | older_flush;
          state_r    <= ST_WAIT;
        end
        ST_WAIT: begin
          ack_mask_r <= ack_mask_r | acc_ack_s;
          tgt_req_r  <= tgt_req_r & ~acc_ack_s;
          killed_r   <= killed_r | older_flush;
          if (all_done_s) begin
            // An older flush arriving in this last cycle also suppresses the refetch.
            hold_r    <= 1'b0;
            refetch_r <= ~(killed_r | older_flush);
            state_r   <= ST_REFETCH;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_REFETCH: begin
          refetch_r <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          tgt_req_r <= {NUM_TGT{1'b0}};
          busy_r    <= 1'b0;
          hold_r    <= 1'b0;
          refetch_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign tgt_req    = tgt_req_r;
  assign maint_busy = busy_r;
  assign hold       = hold_r;
  assign refetch    = refetch_r;
  assign refetch_pc = refetch_pc_r;

endmodule

// File: rtl/pipe_flush_ctrl.sv
// Pipeline hazard controller.
// Merges per-stage flush/stall requests into per-stage kill/hold controls and a
// single fetch redirect, and sequences cache/TLB/BTB maintenance ops through maint_seq.
// Ports:
//   clk, aresetn  clock / async active-low reset
//   bus (slave)   flush_req/flush_pc/stall_req in, flush_out/stall_out/redirect out,
//                 maint_valid/maint_tgt/maint_pc/tgt_ack in, tgt_req/maint_busy out
// Stage 0 is the youngest (IF0), NUM_STAGES-1 the oldest (WB).
module pipe_flush_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int PC_W       = DEF_PC_W,
  parameter int NUM_TGT    = DEF_NUM_TGT,
  parameter int MAINT_STG  = DEF_MAINT_STG
) (
  input logic              clk,
  input logic              aresetn,
  pipe_flush_ctrl_if.slave bus
);

  logic [NUM_STAGES-1:0] kill_s;
  logic [NUM_STAGES-1:0] flush_s;
  logic [NUM_STAGES-1:0] stall_s;
  logic                  any_flush_s;
  logic                  older_flush_s;
  logic [PC_W-1:0]       sel_pc_s;
  logic                  redirect_vld_s;
  logic [PC_W-1:0]       redirect_pc_s;
  logic                  hold_s;
  logic                  refetch_s;
  logic [PC_W-1:0]       refetch_pc_s;

  maint_seq #(
    .PC_W    (PC_W),
    .NUM_TGT (NUM_TGT)
  ) u_maint_seq (
    .clk         (clk),
    .aresetn     (aresetn),
    .maint_valid (bus.maint_valid),
    .maint_tgt   (bus.maint_tgt),
    .maint_pc    (bus.maint_pc),
    .tgt_ack     (bus.tgt_ack),
    .older_flush (older_flush_s),
    .tgt_req     (bus.tgt_req),
    .maint_busy  (bus.maint_busy),
    .hold        (hold_s),
    .refetch     (refetch_s),
    .refetch_pc  (refetch_pc_s)
  );

  // Flushes from stages past the issuing stage kill the maintenance instruction itself.
  assign older_flush_s = |bus.flush_req[NUM_STAGES-1:MAINT_STG+1];

  // Priority encoder: the scan runs young to old so the oldest requester's PC is kept.
  always_comb begin
    any_flush_s = 1'b0;
    sel_pc_s    = {PC_W{1'b0}};
    for (int k = 0; k < NUM_STAGES; k++) begin
      sel_pc_s    = bus.flush_req[k] ? bus.flush_pc[k*PC_W +: PC_W] : sel_pc_s;
      any_flush_s = any_flush_s | bus.flush_req[k];
    end
  end

  // Redirect select: older flush > maintenance refetch > younger flush.
  always_comb begin
    redirect_vld_s = 1'b0;
    redirect_pc_s  = {PC_W{1'b0}};
    if (older_flush_s) begin
      redirect_vld_s = 1'b1;
      redirect_pc_s  = sel_pc_s;
    end else if (refetch_s) begin
      redirect_vld_s = 1'b1;
      redirect_pc_s  = refetch_pc_s;
    end else if (any_flush_s) begin
      redirect_vld_s = 1'b1;
      redirect_pc_s  = sel_pc_s;
    end else begin
      redirect_vld_s = 1'b0;
    end
  end

  // Per-stage merge: a stage is killed by any older flush, held by any older stall,
  // and a kill always beats a hold so the bubble actually propagates.
  for (genvar j = 0; j < NUM_STAGES; j++) begin : g_stage
    if (j == NUM_STAGES - 1) begin : g_oldest
      assign kill_s[j] = 1'b0;
    end else begin : g_younger
      assign kill_s[j] = |bus.flush_req[NUM_STAGES-1:j+1];
    end

    if (j <= MAINT_STG) begin : g_maint_zone
      assign flush_s[j] = kill_s[j] | refetch_s;
      assign stall_s[j] = ((|bus.stall_req[NUM_STAGES-1:j]) | hold_s) & ~flush_s[j];
    end else begin : g_free_zone
      assign flush_s[j] = kill_s[j];
      assign stall_s[j] = (|bus.stall_req[NUM_STAGES-1:j]) & ~flush_s[j];
    end
  end

  assign bus.flush_out    = flush_s;
  assign bus.stall_out    = stall_s;
  assign bus.redirect_vld = redirect_vld_s;
  assign bus.redirect_pc  = redirect_pc_s;

endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// Self-checking bench for pipe_flush_ctrl: per-cycle expectations are pushed to a
// scoreboard queue as stimulus is driven and popped once the outputs have settled.
module tb_pipe_flush_ctrl;

  localparam int NS = 8;
  localparam int PW = 32;
  localparam int NT = 4;
  localparam int MS = 5;

  typedef struct packed {
    logic [NS-1:0] fo;
    logic [NS-1:0] so;
    logic          rv;
    logic [PW-1:0] rpc;
    logic [NT-1:0] req;
    logic          busy;
  } exp_t;

  logic clk;
  logic aresetn;
  int   total;
  int   bad;
  logic [PW-1:0] fpc [NS];
  logic [PW-1:0] m_pc;
  exp_t sb_q [$];

  pipe_flush_ctrl_if #(.NUM_STAGES(NS), .PC_W(PW), .NUM_TGT(NT)) bus ();

  pipe_flush_ctrl #(.NUM_STAGES(NS), .PC_W(PW), .NUM_TGT(NT), .MAINT_STG(MS)) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  pipe_flush_ctrl_chk #(.NUM_TGT(NT)) u_chk (
    .clk         (clk),
    .aresetn     (aresetn),
    .maint_valid (bus.maint_valid),
    .maint_tgt   (bus.maint_tgt),
    .maint_busy  (bus.maint_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference behaviour: hold/rf/req/busy come from the bench's knowledge of the op timeline.
  function automatic exp_t model(input logic [NS-1:0] fr, input logic [NS-1:0] sr,
                                 input logic hold, input logic rf,
                                 input logic [NT-1:0] req, input logic busy);
    exp_t e;
    int   top;
    logic s;
    top = -1;
    for (int k = 0; k < NS; k++) if (fr[k]) top = k;
    e = '0;
    for (int j = 0; j < NS; j++) begin
      e.fo[j] = (j < top) || (rf && j <= MS);
      s = 1'b0;
      for (int i = j; i < NS; i++) s = s | sr[i];
      if (hold && j <= MS) s = 1'b1;
      e.so[j] = s & ~e.fo[j];
    end
    if (top > MS) begin
      e.rv = 1'b1; e.rpc = fpc[top];
    end else if (rf) begin
      e.rv = 1'b1; e.rpc = m_pc;
    end else if (top >= 0) begin
      e.rv = 1'b1; e.rpc = fpc[top];
    end
    e.req  = req;
    e.busy = busy;
    return e;
  endfunction

  task automatic cyc(input string tag, input logic [NS-1:0] fr, input logic [NS-1:0] sr,
                     input logic mv, input logic [NT-1:0] mt, input logic [PW-1:0] mp,
                     input logic [NT-1:0] ack, input logic hold, input logic rf,
                     input logic [NT-1:0] req, input logic busy);
    exp_t e;
    @(posedge clk); #1;
    bus.flush_req   = fr;
    bus.stall_req   = sr;
    bus.maint_valid = mv;
    bus.maint_tgt   = mt;
    bus.maint_pc    = mp;
    bus.tgt_ack     = ack;
    sb_q.push_back(model(fr, sr, hold, rf, req, busy));
    if (mv) m_pc = mp + 32'd4;
    #3;
    if (sb_q.size() == 0) begin
      check_val({tag, ".sb"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_val({tag, ".flush_out"},    32'(bus.flush_out),    32'(e.fo));
      check_val({tag, ".stall_out"},    32'(bus.stall_out),    32'(e.so));
      check_val({tag, ".redirect_vld"}, 32'(bus.redirect_vld), 32'(e.rv));
      if (e.rv) check_val({tag, ".redirect_pc"}, bus.redirect_pc, e.rpc);
      check_val({tag, ".tgt_req"},      32'(bus.tgt_req),      32'(e.req));
      check_val({tag, ".maint_busy"},   32'(bus.maint_busy),   32'(e.busy));
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    m_pc  = 32'd0;
    for (int k = 0; k < NS; k++) fpc[k] = 32'h1c00_0000 + 32'(k) * 32'h10;
    fpc[5] = 32'h1c00_0100;
    fpc[7] = 32'h1c00_8000;
    for (int k = 0; k < NS; k++) bus.flush_pc[k*PW +: PW] = fpc[k];
    bus.flush_req   = 8'h00;
    bus.stall_req   = 8'h00;
    bus.maint_valid = 1'b0;
    bus.maint_tgt   = 4'h0;
    bus.maint_pc    = 32'h0;
    bus.tgt_ack     = 4'h0;
    aresetn         = 1'b0;

    // Reset state
    #3;
    check_val("rst.flush_out",    32'(bus.flush_out),    32'd0);
    check_val("rst.stall_out",    32'(bus.stall_out),    32'd0);
    check_val("rst.redirect_vld", 32'(bus.redirect_vld), 32'd0);
    check_val("rst.tgt_req",      32'(bus.tgt_req),      32'd0);
    check_val("rst.maint_busy",   32'(bus.maint_busy),   32'd0);
    #9 aresetn = 1'b1;

    // Flush / stall merge
    cyc("t1",  8'h20, 8'h00, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    cyc("t2a", 8'h84, 8'h00, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    cyc("t2b", 8'h80, 8'h40, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    cyc("t2c", 8'h00, 8'h10, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    cyc("t2d", 8'h04, 8'h40, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    cyc("t2e", 8'h01, 8'h00, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);

    // Maintenance op, sequential acks, younger flush during WAIT
    cyc("t3c0", 8'h00, 8'h00, 1'b1, 4'b0110, 32'h1c00_0200, 4'h0, 1'b0, 1'b0, 4'h0,    1'b0);
    cyc("t3c1", 8'h00, 8'h00, 1'b0, 4'h0, 32'h0, 4'h0,    1'b1, 1'b0, 4'b0110, 1'b1);
    cyc("t3c2", 8'h08, 8'h00, 1'b0, 4'h0, 32'h0, 4'b0010, 1'b1, 1'b0, 4'b0110, 1'b1);
    cyc("t3c3", 8'h00, 8'h00, 1'b0, 4'h0, 32'h0, 4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1);
    cyc("t3c4", 8'h00, 8'h00, 1'b0, 4'h0, 32'h0, 4'h0,    1'b0, 1'b1, 4'h0,    1'b1);
    cyc("t3c5", 8'h00, 8'h00, 1'b0, 4'h0, 32'h0, 4'h0,    1'b0, 1'b0, 4'h0,    1'b0);

    // Stray ack ignored, joint ack, older flush beats refetch redirect
    cyc("t4c0", 8'h00, 8'h00, 1'b1, 4'b0011, 32'h1c00_0400, 4'h0, 1'b0, 1'b0, 4'h0,    1'b0);
    cyc("t4c1", 8'h00, 8'h00, 1'b0, 4'h0, 32'h0, 4'h0,    1'b1, 1'b0, 4'b0011, 1'b1);
    cyc("t4c2", 8'h00, 8'h00, 1'b0, 4'h0, 32'h0, 4'b1000, 1'b1, 1'b0, 4'b0011, 1'b1);
    cyc("t4c3", 8'h00, 8'h02, 1'b0, 4'h0, 32'h0, 4'b0011, 1'b1, 1'b0, 4'b0011, 1'b1);
    cyc("t4c4", 8'h40, 8'h00, 1'b0, 4'h0, 32'h0, 4'h0,    1'b0, 1'b1, 4'h0,    1'b1);
    cyc("t4c5", 8'h00, 8'h00, 1'b0, 4'h0, 32'h0, 4'h0,    1'b0, 1'b0, 4'h0,    1'b0);

    // Older flush during WAIT kills the refetch
    cyc("t5c0", 8'h00, 8'h00, 1'b1, 4'b0001, 32'h1c00_0500, 4'h0, 1'b0, 1'b0, 4'h0,    1'b0);
    cyc("t5c1", 8'h00, 8'h00, 1'b0, 4'h0, 32'h0, 4'h0,    1'b1, 1'b0, 4'b0001, 1'b1);
    cyc("t5c2", 8'h80, 8'h00, 1'b0, 4'h0, 32'h0, 4'h0,    1'b1, 1'b0, 4'b0001, 1'b1);
    cyc("t5c3", 8'h00, 8'h00, 1'b0, 4'h0, 32'h0, 4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1);
    cyc("t5c4", 8'h00, 8'h00, 1'b0, 4'h0, 32'h0, 4'h0,    1'b0, 1'b0, 4'h0,    1'b1);
    cyc("t5c5", 8'h00, 8'h00, 1'b0, 4'h0, 32'h0, 4'h0,    1'b0, 1'b0, 4'h0,    1'b0);

    // Reset in the middle of WAIT, then a fresh op
    cyc("t6c0", 8'h00, 8'h00, 1'b1, 4'b0100, 32'h1c00_0600, 4'h0, 1'b0, 1'b0, 4'h0,    1'b0);
    cyc("t6c1", 8'h00, 8'h00, 1'b0, 4'h0, 32'h0, 4'h0,    1'b1, 1'b0, 4'b0100, 1'b1);
    cyc("t6c2", 8'h00, 8'h00, 1'b0, 4'h0, 32'h0, 4'h0,    1'b1, 1'b0, 4'b0100, 1'b1);
    aresetn = 1'b0;
    #1;
    check_val("t6rst.tgt_req",    32'(bus.tgt_req),    32'd0);
    check_val("t6rst.maint_busy", 32'(bus.maint_busy), 32'd0);
    check_val("t6rst.stall_out",  32'(bus.stall_out),  32'd0);
    #2 aresetn = 1'b1;
    cyc("t6c3", 8'h00, 8'h00, 1'b0, 4'h0, 32'h0, 4'h0,    1'b0, 1'b0, 4'h0,    1'b0);
    cyc("t6c4", 8'h00, 8'h00, 1'b1, 4'b1000, 32'h1c00_0700, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    cyc("t6c5", 8'h00, 8'h00, 1'b0, 4'h0, 32'h0, 4'h0,    1'b1, 1'b0, 4'b1000, 1'b1);
    cyc("t6c6", 8'h00, 8'h00, 1'b0, 4'h0, 32'h0, 4'b1000, 1'b1, 1'b0, 4'b1000, 1'b1);
    cyc("t6c7", 8'h00, 8'h00, 1'b0, 4'h0, 32'h0, 4'h0,    1'b0, 1'b1, 4'h0,    1'b1);
    cyc("t6c8", 8'h00, 8'h00, 1'b0, 4'h0, 32'h0, 4'h0,    1'b0, 1'b0, 4'h0,    1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
